// File: rtl/gate_tester_if.sv
// gate_tester_if: stimulus/response bundle between the tester and its gate.
// slave = tester side, master = environment (gate model, start source).
interface gate_tester_if;
  logic       i_start;
  logic       o_dut_a;
  logic       o_dut_b;
  logic       i_dut_y;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [3:0] o_table;
  logic [3:0] o_mismatch;

  modport slave (
    input  i_start,
    input  i_dut_y,
    output o_dut_a,
    output o_dut_b,
    output o_busy,
    output o_done,
    output o_pass,
    output o_table,
    output o_mismatch
  );

  modport master (
    output i_start,
    output i_dut_y,
    input  o_dut_a,
    input  o_dut_b,
    input  o_busy,
    input  o_done,
    input  o_pass,
    input  o_table,
    input  o_mismatch
  );
endinterface

// File: rtl/gate_tester.sv
// gate_tester: sweeps a 2-input gate through all four vectors and
// compares the captured truth table against EXPECTED.
// Ports: i_clk, i_rst_n (async, active low), io (gate_tester_if.slave):
//   i_start, i_dut_y in; o_dut_a/b, o_busy, o_done, o_pass,
//   o_table, o_mismatch out.
// Option: GATE_TESTER_LOOP_EN allows DONE -> APPLY back-to-back sweeps.
module gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b0111
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  gate_tester_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] tbl_q, tbl_d;
  logic [3:0] mis_q, mis_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [1:0] vec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tbl_q   <= '0;
      mis_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: begin
        if (io.i_start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          tbl_d   = '0;
          pass_d  = 1'b0;
          mis_d   = '0;
        end
      end
      APPLY: begin
        if (cnt_q == LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        tbl_d[idx_q] = io.i_dut_y;
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 2'd1;
        end
      end
      DONE: begin
        // table is complete here; verdict lands with the done pulse
        done_d  = 1'b1;
        pass_d  = (tbl_q == EXPECTED);
        mis_d   = tbl_q ^ EXPECTED;
        state_d = IDLE;
`ifdef GATE_TESTER_LOOP_EN
        if (io.i_start) begin
          state_d = APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          tbl_d   = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vec = '0;
    unique case (1'b1)
      (state_q == APPLY),
      (state_q == SAMPLE): vec = idx_q;
      default:             vec = '0;
    endcase
  end

  assign io.o_dut_a    = vec[0];
  assign io.o_dut_b    = vec[1];
  assign io.o_busy     = (state_q != IDLE);
  assign io.o_done     = done_q;
  assign io.o_pass     = pass_q;
  assign io.o_table    = tbl_q;
  assign io.o_mismatch = mis_q;

endmodule
